// File: rtl/booth_rca_mult_seq_pkg.sv
// Shared definitions for the Booth multiplier path: FSM states, operand width
// and the Booth recoding codes that select the adder operand.
// Imported by the top and by the ripple-carry adder.
package booth_rca_mult_seq_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // {Q[0], q_m1} recoding: 01 adds M, 10 subtracts M, 00/11 add zero
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_rca_mult_seq_rca.sv
// Purpose: WIDTH-bit ripple-carry adder with carry-out and signed overflow flag.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module booth_rca_mult_seq_rca
    import booth_rca_mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             of_o
);

    logic             carry;
    logic             carry_into_msb;
    logic [WIDTH-1:0] sum_d;

    // Ripple the carry bit by bit; remember the carry entering the MSB for overflow
    always_comb begin
        carry          = cin_i;
        carry_into_msb = 1'b0;
        sum_d          = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                carry_into_msb = carry;
            end
            sum_d[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o  = sum_d;
    assign cout_o = carry;
    assign of_o   = carry ^ carry_into_msb;

endmodule

// File: rtl/booth_rca_mult_seq.sv
// Purpose: signed WIDTHxWIDTH radix-2 Booth multiplier sharing one ripple-carry adder.
// Latency: done_o high in the cycle after accept edge + WIDTH; one multiply per WIDTH+2 cycles.
// Backpressure: start_i is accepted only while ready_o=1; requests while busy are dropped.
module booth_rca_mult_seq
    import booth_rca_mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    mult_state_e          state_q;
    logic [WIDTH-1:0]     a_q;        // accumulator (upper half of partial product)
    logic [WIDTH-1:0]     q_q;        // multiplier, shifted out as product lower half
    logic                 qm1_q;      // Booth look-behind bit
    logic [WIDTH-1:0]     m_q;        // multiplicand
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     rca_b;
    logic                 rca_cin;
    logic [WIDTH-1:0]     rca_sum;
    logic                 rca_of;
    logic                 rca_cout_unused;
    logic                 sign_fix;
    logic [2*WIDTH:0]     shift_d;    // next {A, Q, q_m1}

    // Select the adder operand from the Booth recoding of {Q[0], q_m1}
    always_comb begin
        rca_b   = '0;
        rca_cin = 1'b0;
        case ({q_q[0], qm1_q})
            BOOTH_ADD: rca_b = m_q;
            BOOTH_SUB: begin
                rca_b   = ~m_q;
                rca_cin = 1'b1;
            end
            default: ;
        endcase
    end

    booth_rca_mult_seq_rca #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a_i    (a_q),
        .b_i    (rca_b),
        .cin_i  (rca_cin),
        .sum_o  (rca_sum),
        .cout_o (rca_cout_unused),
        .of_o   (rca_of)
    );

    // The sum MSB is wrong when the add overflows (e.g. subtracting 0x80000000);
    // flipping it by the overflow flag recovers the true sign for the shift-in bit.
    assign sign_fix = rca_sum[WIDTH-1] ^ rca_of;
    assign shift_d  = {sign_fix, rca_sum, q_q};

    // Control FSM, counter, shift register and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        m_q     <= a_i;
                        q_q     <= b_i;
                        a_q     <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    {a_q, q_q, qm1_q} <= shift_d;
                    cnt_q             <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Publish the final shifted {A, Q} so it is visible in the DONE cycle
                        product_q <= shift_d[2*WIDTH:1];
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule
